// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin arbiter and pulse sequencer for a shared
// NAND-style SR latch. Each granted operation drives one registered,
// active-low pulse on S or R. The block then waits for the latch to settle
// and reads back the synchronised Qa to confirm the latch state.
module sr_latch_ctrl #(
    parameter int N_REQ      = 4,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op,
    output logic [N_REQ-1:0] gnt,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             latch_S,
    output logic             latch_R,
    output logic             latch_rst,
    input  logic             latch_Qa,
    output logic             latch_state
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_q, op_d;
    logic            busy_q, busy_d;
    logic            latch_S_q, latch_S_d;
    logic            latch_R_q, latch_R_d;
    logic            latch_rst_q;
    logic [1:0]      qa_sync_q;

    // arbiter scratch
    logic            found;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;

    // Round-robin search: walk upward from rr_ptr, wrapping at N_REQ-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
            cand = (cand == PW'(N_REQ - 1)) ? '0 : cand + PW'(1);
        end
    end

    // Next-state logic plus the combinational gnt/done/err outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        gnt      = '0;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE: begin
                // latch_rst_q stays high for one edge after reset release.
                // Requests seen in that cycle wait for the next one.
                if (!latch_rst_q && found) begin
                    gnt[gnt_idx] = 1'b1;
                    op_d         = op[gnt_idx];
                    rr_ptr_d     = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CW'(PULSE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                done    = 1'b1;
                err     = (qa_sync_q[1] != op_q);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // S/R are driven from flops computed off the next state. Only one of
    // them can ever be low, because op_d selects exactly one.
    always_comb begin
        latch_S_d = ~((state_d == PULSE) &&  op_d);
        latch_R_d = ~((state_d == PULSE) && ~op_d);
    end

    // Control state. Reset returns everything to idle with both drives high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            latch_S_q <= 1'b1;
            latch_R_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            latch_S_q <= latch_S_d;
            latch_R_q <= latch_R_d;
        end
    end

    // Latch reset: held during system reset and released on the first edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) latch_rst_q <= 1'b1;
        else        latch_rst_q <= 1'b0;
    end

    // Two-flop synchroniser for the asynchronous latch Qa output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) qa_sync_q <= 2'b00;
        else        qa_sync_q <= {qa_sync_q[0], latch_Qa};
    end

    assign busy        = busy_q;
    assign latch_S     = latch_S_q;
    assign latch_R     = latch_R_q;
    assign latch_rst   = latch_rst_q;
    assign latch_state = qa_sync_q[1];

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Testbench for sr_latch_ctrl. It uses a vector table for the directed
// sequences and hand-written reset and round-robin cases. A random phase is
// checked against a transaction-level model.
module tb_sr_latch_ctrl;
    localparam int N   = 4;
    localparam int P   = 2;
    localparam int S   = 2;
    localparam int LAT = 1 + P + S;   // grant -> done

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] op = '0;
    logic [N-1:0] gnt;
    logic         done, err, busy, latch_S, latch_R, latch_rst, latch_Qa, latch_state;
    logic         qa_int = 1'b0;
    logic         stuck0 = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int viol = 0;

    typedef struct packed {
        logic [3:0] rq;
        logic [3:0] o;
        logic       sk;
        logic [3:0] g;
        logic       d;
        logic       e;
        logic       s;
        logic       r;
        logic       cs;
        logic       st;
    } vec_t;

    vec_t       tv [25];
    logic [3:0] rr_exp [5];

    always #5 clk = ~clk;

    sr_latch_ctrl #(.N_REQ(N), .PULSE_CYC(P), .SETTLE_CYC(S)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .gnt(gnt),
        .done(done), .err(err), .busy(busy),
        .latch_S(latch_S), .latch_R(latch_R), .latch_rst(latch_rst),
        .latch_Qa(latch_Qa), .latch_state(latch_state)
    );

    // Behavioural NAND latch: reset wins, then a low S sets Qa and a low R
    // clears it. stuck0 forces the pin low to model a dead latch.
    always @(latch_S or latch_R or latch_rst) begin
        if (latch_rst)     qa_int = 1'b0;
        else if (!latch_S) qa_int = 1'b1;
        else if (!latch_R) qa_int = 1'b0;
    end
    assign latch_Qa = stuck0 ? 1'b0 : qa_int;

    // Invariants on every cycle.
    always @(negedge clk) begin
        if (!latch_S && !latch_R) viol++;
        if ($countones(gnt) > 1)  viol++;
        if ((gnt != '0) && busy)  viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        req    = '0;
        op     = '0;
        stuck0 = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("latch_rst after release", 32'(latch_rst), 32'd0);
    endtask

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] o, logic sk, logic [3:0] g,
                                logic d, logic e, logic s, logic r, logic cs, logic st);
        mk = {rq, o, sk, g, d, e, s, r, cs, st};
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        req    op   stk  gnt  done err  S  R  chk st
        tv[0]  = mk(4'h1, 4'h1, 0, 4'h1, 0, 0, 1, 1, 0, 0);
        tv[1]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
        tv[2]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 0, 0);
        tv[3]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[4]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[5]  = mk(4'h0, 4'h0, 0, 4'h0, 1, 0, 1, 1, 1, 1);
        tv[6]  = mk(4'h4, 4'h0, 0, 4'h4, 0, 0, 1, 1, 0, 0);
        tv[7]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
        tv[8]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
        tv[9]  = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[10] = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[11] = mk(4'h0, 4'h0, 0, 4'h0, 1, 0, 1, 1, 1, 0);
        tv[12] = mk(4'h8, 4'h8, 1, 4'h8, 0, 0, 1, 1, 0, 0);
        tv[13] = mk(4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 1, 0, 0);
        tv[14] = mk(4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 1, 0, 0);
        tv[15] = mk(4'h0, 4'h0, 1, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[16] = mk(4'h0, 4'h0, 1, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[17] = mk(4'h0, 4'h0, 1, 4'h0, 1, 1, 1, 1, 1, 0);
        tv[18] = mk(4'h2, 4'h0, 0, 4'h2, 0, 0, 1, 1, 0, 0);
        tv[19] = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
        tv[20] = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
        tv[21] = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[22] = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        tv[23] = mk(4'h0, 4'h0, 0, 4'h0, 1, 0, 1, 1, 1, 0);
        tv[24] = mk(4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
        rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4; rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;

        // ---- reset values, effective immediately ----
        #2 reset = 1'b0;
        #1;
        chk("rst latch_S",   32'(latch_S),   32'd1);
        chk("rst latch_R",   32'(latch_R),   32'd1);
        chk("rst latch_rst", 32'(latch_rst), 32'd1);
        chk("rst gnt",       32'(gnt),       32'd0);
        chk("rst done/err",  32'({done, err}), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        do_reset();

        // ---- directed table: set, clear, stuck-at-0 readback, recovery ----
        for (int i = 0; i < 25; i++) begin
            req    = tv[i].rq;
            op     = tv[i].o;
            stuck0 = tv[i].sk;
            @(negedge clk);
            chk($sformatf("v%0d gnt", i),  32'(gnt),     32'(tv[i].g));
            chk($sformatf("v%0d done", i), 32'(done),    32'(tv[i].d));
            chk($sformatf("v%0d err", i),  32'(err),     32'(tv[i].e));
            chk($sformatf("v%0d S", i),    32'(latch_S), 32'(tv[i].s));
            chk($sformatf("v%0d R", i),    32'(latch_R), 32'(tv[i].r));
            if (tv[i].cs) chk($sformatf("v%0d latch_state", i), 32'(latch_state), 32'(tv[i].st));
            if (i == 1 || i == 5) chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
            if (i == 24) chk("v24 busy", 32'(busy), 32'd0);
            tick();
        end

        // ---- round robin with all requests held ----
        begin
            int         gc [$];
            logic [3:0] gv [$];
            do_reset();
            req = 4'hF;
            op  = 4'h5;
            for (int c = 0; c < 60 && gc.size() < 5; c++) begin
                @(negedge clk);
                if (gnt != '0) begin
                    gc.push_back(c);
                    gv.push_back(gnt);
                end
                tick();
            end
            req = '0;
            chk("rr grant count", 32'(gc.size()), 32'd5);
            if (gc.size() > 0) chk("rr first grant cycle", 32'(gc[0]), 32'd0);
            for (int i = 0; i < gc.size(); i++) begin
                chk($sformatf("rr grant %0d", i), 32'(gv[i]), 32'(rr_exp[i]));
                if (i > 0) chk($sformatf("rr spacing %0d", i), 32'(gc[i] - gc[i-1]), 32'(LAT + 1));
            end
        end

        // ---- reset asserted in the middle of a set pulse ----
        do_reset();
        req = 4'h1;
        op  = 4'h1;
        @(negedge clk);
        chk("mid grant", 32'(gnt), 32'h1);
        tick();
        tick();
        @(negedge clk);
        chk("mid S low at T+2", 32'(latch_S), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("mid rst S",    32'(latch_S),   32'd1);
        chk("mid rst R",    32'(latch_R),   32'd1);
        chk("mid rst lrst", 32'(latch_rst), 32'd1);
        chk("mid rst done", 32'({done, err, busy}), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mid rel gnt held", 32'(gnt),       32'd0);
        chk("mid rel lrst",     32'(latch_rst), 32'd1);
        tick();
        @(negedge clk);
        chk("mid regrant lrst", 32'(latch_rst), 32'd0);
        chk("mid regrant",      32'(gnt),       32'h1);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) req = '0;
        end
        @(negedge clk);
        chk("mid redo done", 32'({done, err}), 32'b10);
        chk("mid redo state", 32'(latch_state), 32'd1);
        tick();

        // ---- request raised while latch_rst is still high ----
        reset = 1'b0;
        req   = '0;
        tick();
        tick();
        reset = 1'b1;
        req   = 4'h2;
        op    = 4'h0;
        @(negedge clk);
        chk("early req gnt", 32'(gnt), 32'd0);
        tick();
        @(negedge clk);
        chk("early req next gnt", 32'(gnt), 32'h2);
        tick();
        req = '0;
        repeat (LAT) tick();

        // ---- random traffic against a transaction-level model ----
        begin
            bit         pend [N];
            bit         pop  [N];
            int         m_free;
            int         m_ptr;
            int         dq_c [$];
            bit         dq_op [$];
            do_reset();
            m_free = 0;
            m_ptr  = 0;
            for (int i = 0; i < N; i++) begin pend[i] = 0; pop[i] = 0; end
            for (int c = 0; c < 400; c++) begin
                logic [N-1:0] rv, ov, eg;
                int           g;
                bit           exp_done;
                for (int i = 0; i < N; i++) begin
                    if (!pend[i]) begin
                        if ($urandom_range(3) == 0) begin
                            pend[i] = 1;
                            pop[i]  = 1'($urandom_range(1));
                        end
                    end else if ($urandom_range(40) == 0) begin
                        pend[i] = 0;    // requester gives up before being granted
                    end
                end
                rv = '0;
                ov = '0;
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) rv |= N'(1 << i);
                    if (pop[i])  ov |= N'(1 << i);
                end
                req = rv;
                op  = ov;
                g  = -1;
                eg = '0;
                if (c >= m_free) begin
                    for (int k = 0; k < N; k++) begin
                        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    end
                end
                if (g >= 0) begin
                    eg = N'(1 << g);
                    dq_c.push_back(c + LAT);
                    dq_op.push_back(pop[g]);
                    m_free = c + LAT + 1;
                    m_ptr  = (g + 1) % N;
                end
                @(negedge clk);
                chk($sformatf("rnd c%0d gnt", c), 32'(gnt), 32'(eg));
                exp_done = (dq_c.size() > 0) && (dq_c[0] == c);
                chk($sformatf("rnd c%0d done/err", c), 32'({done, err}), 32'({exp_done, 1'b0}));
                if (exp_done) begin
                    chk($sformatf("rnd c%0d latch_state", c), 32'(latch_state), 32'(dq_op[0]));
                    void'(dq_c.pop_front());
                    void'(dq_op.pop_front());
                end
                if (g >= 0) pend[g] = 0;
                tick();
            end
        end

        chk("invariants", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
